// File: rtl/fifo_wr_stream_adapter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_stream_adapter_if
//
// Bundles the signals around the async-FIFO write-side front end:
//   - source stream   : s_data, s_valid (to adapter), s_ready (from adapter)
//   - FIFO write side : wfull, wq2_rptr (to adapter), winc, wdata (from adapter)
//   - status          : wlevel, walmost_full, wwords (from adapter)
//
// Modports:
//   slave  - the adapter itself
//   master - whatever sits around the adapter (producer + FIFO pointer logic)
// ---------------------------------------------------------------------------
interface fifo_wr_stream_adapter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int CNT_WIDTH  = 16
);
    // source stream
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    // FIFO write-pointer interface
    logic                  wfull;
    logic [PTR_WIDTH:0]    wq2_rptr;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;

    // status
    logic [PTR_WIDTH:0]    wlevel;
    logic                  walmost_full;
    logic [CNT_WIDTH-1:0]  wwords;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        input  wfull,
        input  wq2_rptr,
        output winc,
        output wdata,
        output wlevel,
        output walmost_full,
        output wwords
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        output wfull,
        output wq2_rptr,
        input  winc,
        input  wdata,
        input  wlevel,
        input  walmost_full,
        input  wwords
    );
endinterface

// File: rtl/fifo_wr_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_wr_stream_adapter
//
// Producer-side front end for the async FIFO write domain. Takes a
// valid/ready source stream and turns it into winc/wdata strobes for the
// FIFO write-pointer block, never writing while wfull is high. A 2-entry
// skid buffer (output register + skid register) lets s_ready be a pure
// register decode while still sustaining one word per cycle.
//
// The synchronized gray read pointer is converted to binary and compared
// with a local copy of the write pointer to report the fill level,
// an almost-full flag and a saturating count of written words.
//
// Ports:
//   wclk    - write-domain clock
//   wrst_n  - asynchronous active-low reset
//   bus     - fifo_wr_stream_adapter_if.slave:
//               s_data/s_valid/s_ready  source stream
//               wfull, wq2_rptr          from FIFO write-pointer logic
//               winc, wdata              FIFO write strobe and data
//               wlevel                   fill level, 0..2^PTR_WIDTH
//               walmost_full             wlevel >= AF_THRESH
//               wwords                   saturating written-word count
// ---------------------------------------------------------------------------
module fifo_wr_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_THRESH  = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    fifo_wr_stream_adapter_if.slave   bus
);

    localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH + 1)'(AF_THRESH);

    // -----------------------------------------------------------------------
    // Skid buffer state
    //   EMPTY : nothing held
    //   ONE   : out_data_reg holds the word presented to the FIFO
    //   TWO   : out_data_reg presented, skid_data_reg holds the next word
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;

    logic                  out_valid;
    logic                  skid_valid;
    logic                  accept;
    logic                  pop;

    logic                  load_out_from_in;
    logic                  load_out_from_skid;
    logic                  load_skid;

    // Both flags are decoded straight from the state register, so s_ready
    // has no combinational dependency on wfull or s_valid.
    assign out_valid  = (state_reg != ST_EMPTY);
    assign skid_valid = (state_reg == ST_TWO);

    assign accept = bus.s_valid & ~skid_valid;
    // The write strobe is gated by wfull here so a write can never be
    // issued against a full FIFO, regardless of the buffer state.
    assign pop    = out_valid & ~bus.wfull;

    assign bus.s_ready = ~skid_valid;
    assign bus.winc    = pop;
    assign bus.wdata   = out_data_reg;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and data-register load enables
    // -----------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;

        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next       = ST_ONE;
                    load_out_from_in = 1'b1;
                end
            end

            ST_ONE: begin
                if (accept && pop) begin
                    // Word leaves and a new one replaces it: no bubble.
                    state_next       = ST_ONE;
                    load_out_from_in = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end

            ST_TWO: begin
                // accept is impossible here (s_ready=0)
                if (pop) begin
                    state_next         = ST_ONE;
                    load_out_from_skid = 1'b1;
                end
            end

            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            out_data_reg  <= '0;
            skid_data_reg <= '0;
        end else begin
            if (load_out_from_in) begin
                out_data_reg <= bus.s_data;
            end else if (load_out_from_skid) begin
                out_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
                skid_data_reg <= bus.s_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Gray to binary conversion of the synchronized read pointer.
    // Each binary bit is the XOR of all gray bits at or above it; written
    // as an explicit reduction so no bit depends on another bit of rbin.
    // -----------------------------------------------------------------------
    logic [PTR_WIDTH:0] rbin;

    generate
        genvar gi;
        for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
            assign rbin[gi] = ^bus.wq2_rptr[PTR_WIDTH:gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Local write count mirrors the FIFO write pointer (binary, wraps at
    // 2^(PTR_WIDTH+1)). Level uses the post-write value so wlevel lines up
    // with the registered wfull of the pointer block.
    // -----------------------------------------------------------------------
    logic [PTR_WIDTH:0]   wcount_reg;
    logic [PTR_WIDTH:0]   wcount_next;
    logic [PTR_WIDTH:0]   wlevel_reg;
    logic [PTR_WIDTH:0]   wlevel_next;
    logic                 walmost_full_reg;
    logic                 walmost_full_next;
    logic [CNT_WIDTH-1:0] wwords_reg;
    logic [CNT_WIDTH-1:0] wwords_next;

    assign wcount_next       = wcount_reg + {{PTR_WIDTH{1'b0}}, pop};
    assign wlevel_next       = wcount_next - rbin;
    assign walmost_full_next = (wlevel_next >= AF_LEVEL);

    // Saturating counter: stops at all-ones rather than wrapping.
    assign wwords_next = (pop && (wwords_reg != {CNT_WIDTH{1'b1}}))
                       ? wwords_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                       : wwords_reg;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wcount_reg       <= '0;
            wlevel_reg       <= '0;
            walmost_full_reg <= 1'b0;
            wwords_reg       <= '0;
        end else begin
            wcount_reg       <= wcount_next;
            wlevel_reg       <= wlevel_next;
            walmost_full_reg <= walmost_full_next;
            wwords_reg       <= wwords_next;
        end
    end

    assign bus.wlevel       = wlevel_reg;
    assign bus.walmost_full = walmost_full_reg;
    assign bus.wwords       = wwords_reg;

endmodule

// File: tb/tb_fifo_wr_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_stream_adapter
//
// Self-checking bench for fifo_wr_stream_adapter (DATA_WIDTH=8, PTR_WIDTH=3,
// AF_THRESH=6, CNT_WIDTH=16). Accepted words are pushed to a scoreboard
// queue and popped/compared whenever winc is seen. A small model of the
// FIFO write pointer tracks the expected level, almost-full and word count,
// and can drive wfull itself (auto_full) or follow a forced value.
// ---------------------------------------------------------------------------
module tb_fifo_wr_stream_adapter;

    logic wclk;
    logic wrst_n;

    fifo_wr_stream_adapter_if #(
        .DATA_WIDTH (8),
        .PTR_WIDTH  (3),
        .CNT_WIDTH  (16)
    ) bus ();

    fifo_wr_stream_adapter #(
        .DATA_WIDTH (8),
        .PTR_WIDTH  (3),
        .AF_THRESH  (6),
        .CNT_WIDTH  (16)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // check bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard and write-pointer model
    logic [7:0] sb[$];
    logic [3:0] mwptr       = 4'd0;
    logic [3:0] exp_level   = 4'd0;
    int         exp_words   = 0;
    logic       full_model  = 1'b0;
    logic       auto_full   = 1'b0;
    logic       force_full  = 1'b0;
    logic [3:0] rptr_gray   = 4'd0;
    int         winc_count  = 0;

    // per-cycle observations
    logic       winc_seen   = 1'b0;
    logic       sready_seen = 1'b0;
    logic [7:0] wdata_seen  = 8'd0;
    logic       accepted    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic [3:0] lvl;
        bus.s_valid  = v;
        bus.s_data   = d;
        bus.wfull    = auto_full ? full_model : force_full;
        bus.wq2_rptr = rptr_gray;
        #1;
        check("wlevel", 32'(bus.wlevel), 32'(exp_level));
        check("walmost_full", 32'(bus.walmost_full), 32'(exp_level >= 4'd6));
        check("wwords", 32'(bus.wwords), exp_words);
        check("no_write_when_full", 32'(bus.winc & bus.wfull), 32'd0);
        winc_seen   = bus.winc;
        sready_seen = bus.s_ready;
        wdata_seen  = bus.wdata;
        accepted    = v & bus.s_ready;
        if (bus.winc) begin
            if (sb.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                check("wdata_order", 32'(bus.wdata), 32'(sb.pop_front()));
            end
            $display("write data=%02h count=%0d", bus.wdata, winc_count + 1);
            mwptr      = mwptr + 4'd1;
            exp_words  = exp_words + 1;
            winc_count = winc_count + 1;
        end
        if (accepted) begin
            sb.push_back(d);
        end
        lvl        = mwptr - gray2bin(rptr_gray);
        exp_level  = lvl;
        full_model = (lvl == 4'd8);
        @(negedge wclk);
    endtask

    // Present a word until it is accepted, within a cycle budget.
    task automatic send_word(input logic [7:0] d);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, d);
            if (accepted) return;
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // Assert reset mid-cycle (called at a falling edge), check outputs at
    // once, clear the model and release at the next falling edge.
    task automatic apply_reset(input string tag);
        #2 wrst_n = 1'b0;
        #1;
        check({tag, "_s_ready"},      32'(bus.s_ready),      32'd1);
        check({tag, "_winc"},         32'(bus.winc),         32'd0);
        check({tag, "_wdata"},        32'(bus.wdata),        32'd0);
        check({tag, "_wlevel"},       32'(bus.wlevel),       32'd0);
        check({tag, "_walmost_full"}, 32'(bus.walmost_full), 32'd0);
        check({tag, "_wwords"},       32'(bus.wwords),       32'd0);
        sb.delete();
        mwptr        = 4'd0;
        exp_level    = 4'd0;
        exp_words    = 0;
        full_model   = 1'b0;
        auto_full    = 1'b0;
        force_full   = 1'b0;
        rptr_gray    = 4'd0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
        bus.wfull    = 1'b0;
        bus.wq2_rptr = 4'd0;
        $display("reset %s", tag);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        wrst_n       = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
        bus.wfull    = 1'b0;
        bus.wq2_rptr = 4'd0;
        @(negedge wclk);
        apply_reset("init");

        // ---- single word: accept at N, write at N+1 only ----
        cycle(1'b1, 8'hA5);
        check("sw_no_write_at_n", 32'(winc_seen), 32'd0);
        cycle(1'b0, 8'h00);
        check("sw_write_at_n1", 32'(winc_seen), 32'd1);
        check("sw_wdata", 32'(wdata_seen), 32'hA5);
        cycle(1'b0, 8'h00);
        check("sw_single_pulse", 32'(winc_seen), 32'd0);
        check("sw_wwords", 32'(bus.wwords), 32'd1);
        check("sw_wlevel", 32'(bus.wlevel), 32'd1);

        // ---- stall: wfull while streaming fills the skid ----
        send_word(8'hB0);
        send_word(8'hB1);
        force_full = 1'b1;
        send_word(8'hB2);
        cycle(1'b1, 8'hB3);
        check("stall_ready_low", 32'(sready_seen), 32'd0);
        cycle(1'b1, 8'hB3);
        check("stall_ready_held", 32'(sready_seen), 32'd0);
        force_full = 1'b0;
        send_word(8'hB3);
        send_word(8'hB4);
        idle(3);
        check("stall_ready_back", 32'(sready_seen), 32'd1);
        check("stall_drained", 32'(sb.size()), 32'd0);
        check("stall_words", 32'(bus.wwords), 32'd6);

        // ---- reset mid-stream while holding two words ----
        force_full = 1'b1;
        send_word(8'hC0);
        send_word(8'hC1);
        cycle(1'b1, 8'hC2);
        check("pre_reset_two", 32'(sready_seen), 32'd0);
        apply_reset("mid");
        cycle(1'b1, 8'h3C);
        check("post_reset_no_write", 32'(winc_seen), 32'd0);
        cycle(1'b0, 8'h00);
        check("post_reset_write", 32'(winc_seen), 32'd1);
        check("post_reset_wdata", 32'(wdata_seen), 32'h3C);
        apply_reset("clean");

        // ---- fill: 8 back-to-back words, model raises wfull ----
        auto_full = 1'b1;
        base = winc_count;
        for (int i = 0; i < 8; i++) send_word(8'h10 + 8'(i));
        idle(3);
        check("fill_writes", 32'(winc_count - base), 32'd8);
        check("fill_wlevel", 32'(bus.wlevel), 32'd8);
        check("fill_almost_full", 32'(bus.walmost_full), 32'd1);

        // ---- level decode: read pointer gray 0111 = 5 ----
        rptr_gray = 4'b0111;
        idle(2);
        check("decode_wlevel", 32'(bus.wlevel), 32'd3);
        check("decode_almost_full", 32'(bus.walmost_full), 32'd0);

        // ---- wrap: 20 writes total, read pointer gray 1001 = 14 ----
        rptr_gray = 4'b1100;
        for (int i = 0; i < 6; i++) send_word(8'h40 + 8'(i));
        idle(2);
        rptr_gray = 4'b1001;
        for (int i = 0; i < 6; i++) send_word(8'h50 + 8'(i));
        idle(3);
        check("wrap_wlevel", 32'(bus.wlevel), 32'd6);
        check("wrap_almost_full", 32'(bus.walmost_full), 32'd1);
        check("wrap_wwords", 32'(bus.wwords), 32'd20);
        check("wrap_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
